// File: rtl/cnt_sequencer_if.sv
// cnt_sequencer_if: configuration handshake bundle for cnt_sequencer.
// Ports: cfg_valid/cfg_mode/cfg_limit/cfg_presc from master, cfg_ready from slave.
interface cnt_sequencer_if #(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 16
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [1:0]         cfg_mode;
  logic [WIDTH-1:0]   cfg_limit;
  logic [PRESC_W-1:0] cfg_presc;

  modport master (
    output cfg_valid,
    output cfg_mode,
    output cfg_limit,
    output cfg_presc,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_mode,
    input  cfg_limit,
    input  cfg_presc,
    output cfg_ready
  );
endinterface

// File: rtl/cnt_sequencer.sv
// cnt_sequencer: prescaled 4-mode counter sequencer (FREE/ONESHOT/RELOAD/BOUNCE).
// Ports: clk, rst (async high), cfg (slave handshake), start/pause/stop in;
// count/dir/busy/done/tick out; CNT_SEQUENCER_IRQ_EN adds irq out, irq_clr in.
module cnt_sequencer #(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  cnt_sequencer_if.slave   cfg,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             busy,
  output logic             done,
  output logic             tick
`ifdef CNT_SEQUENCER_IRQ_EN
  ,
  output logic             irq,
  input  logic             irq_clr
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_e;

  localparam logic [1:0] M_FREE    = 2'd0;
  localparam logic [1:0] M_ONESHOT = 2'd1;
  localparam logic [1:0] M_RELOAD  = 2'd2;
  localparam logic [1:0] M_BOUNCE  = 2'd3;

  localparam logic [WIDTH-1:0]   C_ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0]   C_MAX = '1;
  localparam logic [PRESC_W-1:0] P_ONE = PRESC_W'(1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic               dir_q, dir_d;
  logic               tick_q, tick_d;
  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic [1:0]         mode_q, mode_d;
  logic [WIDTH-1:0]   limit_q, limit_d;
  logic [PRESC_W-1:0] presc_q, presc_d;

  logic idle_or_done;
  logic xfer;

  assign idle_or_done = (state_q == S_IDLE) || (state_q == S_DONE);
  assign xfer         = cfg.cfg_valid && idle_or_done;

  assign cfg.cfg_ready = idle_or_done;
  assign count         = count_q;
  assign dir           = dir_q;
  assign tick          = tick_q;
  assign busy          = (state_q == S_RUN);
  assign done          = (state_q == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      dir_q   <= 1'b0;
      tick_q  <= 1'b0;
      pcnt_q  <= '0;
      mode_q  <= M_FREE;
      limit_q <= '1;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dir_q   <= dir_d;
      tick_q  <= tick_d;
      pcnt_q  <= pcnt_d;
      mode_q  <= mode_d;
      limit_q <= limit_d;
      presc_q <= presc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dir_d   = dir_q;
    tick_d  = 1'b0;
    pcnt_d  = pcnt_q;
    mode_d  = mode_q;
    limit_d = limit_q;
    presc_d = presc_q;

    // Shadow load; a start on the same edge runs with the new values.
    if (xfer) begin
      mode_d  = cfg.cfg_mode;
      limit_d = cfg.cfg_limit;
      presc_d = cfg.cfg_presc;
    end

    if (stop) begin
      state_d = S_IDLE;
    end else if (start && idle_or_done) begin
      state_d = S_RUN;
      count_d = '0;
      pcnt_d  = '0;
      dir_d   = 1'b0;
    end else if (start && state_q == S_PAUSE) begin
      state_d = S_RUN;
    end else if (state_q == S_RUN && pause && !start) begin
      state_d = S_PAUSE;
    end else if (state_q == S_RUN) begin
      if (pcnt_q == presc_q) begin
        pcnt_d = '0;
        unique case (mode_q)
          M_FREE: begin
            count_d = count_q + C_ONE;
            tick_d  = (count_q == C_MAX);
          end
          M_ONESHOT: begin
            if (count_q == limit_q) begin
              state_d = S_DONE;
              tick_d  = 1'b1;
            end else begin
              count_d = count_q + C_ONE;
            end
          end
          M_RELOAD: begin
            if (count_q == limit_q) begin
              count_d = '0;
              tick_d  = 1'b1;
            end else begin
              count_d = count_q + C_ONE;
            end
          end
          M_BOUNCE: begin
            // Endpoint step only flips direction; count dwells one step.
            if (!dir_q) begin
              if (count_q == limit_q) begin
                dir_d  = 1'b1;
                tick_d = 1'b1;
              end else begin
                count_d = count_q + C_ONE;
              end
            end else begin
              if (count_q == '0) begin
                dir_d  = 1'b0;
                tick_d = 1'b1;
              end else begin
                count_d = count_q - C_ONE;
              end
            end
          end
          default: ;
        endcase
      end else begin
        pcnt_d = pcnt_q + P_ONE;
      end
    end
  end

`ifdef CNT_SEQUENCER_IRQ_EN
  logic irq_q;

  assign irq = irq_q;

  // Set wins over clear so a coincident event is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else if (tick_q) begin
      irq_q <= 1'b1;
    end else if (irq_clr) begin
      irq_q <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_cnt_sequencer.sv
// tb_cnt_sequencer: directed self-checking bench for cnt_sequencer.
// Covers reset, all four modes, pause/resume, handshake stall and priority.
module tb_cnt_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       pause;
  logic       stop;
  logic [7:0] count;
  logic       dir;
  logic       busy;
  logic       done;
  logic       tick;
`ifdef CNT_SEQUENCER_IRQ_EN
  logic       irq;
  logic       irq_clr;
`endif

  int checks = 0;
  int fails  = 0;

  cnt_sequencer_if #(.WIDTH(8), .PRESC_W(16)) cif ();

  cnt_sequencer #(.WIDTH(8), .PRESC_W(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .cfg     (cif),
    .start   (start),
    .pause   (pause),
    .stop    (stop),
    .count   (count),
    .dir     (dir),
    .busy    (busy),
    .done    (done),
    .tick    (tick)
`ifdef CNT_SEQUENCER_IRQ_EN
    ,
    .irq     (irq),
    .irq_clr (irq_clr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg_set(input logic [1:0] m, input logic [7:0] l,
                         input logic [15:0] p);
    cif.cfg_valid = 1'b1;
    cif.cfg_mode  = m;
    cif.cfg_limit = l;
    cif.cfg_presc = p;
  endtask

  logic [7:0] rl_cnt [8] = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2, 8'd3, 8'd0};
  logic [7:0] bn_cnt [7] = '{8'd1, 8'd2, 8'd2, 8'd1, 8'd0, 8'd0, 8'd1};
  logic       bn_dir [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic       bn_tck [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    int ticks;
    logic [7:0] c4;

    rst   = 1'b1;
    start = 1'b0;
    pause = 1'b0;
    stop  = 1'b0;
    cif.cfg_valid = 1'b0;
    cif.cfg_mode  = 2'd0;
    cif.cfg_limit = 8'd0;
    cif.cfg_presc = 16'd0;
`ifdef CNT_SEQUENCER_IRQ_EN
    irq_clr = 1'b0;
`endif

    #2;
    chk("rst_count", count, 0);
    chk("rst_ready", cif.cfg_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tick", tick, 0);
    chk("rst_dir", dir, 0);
    cyc(2);
    rst = 1'b0;

    // Reset mid-count at 0x37
    cfg_set(2'd0, 8'hff, 16'd0);
    start = 1'b1;
    cyc(1);
    cif.cfg_valid = 1'b0;
    start = 1'b0;
    chk("a_start_cnt", count, 0);
    chk("a_ready_run", cif.cfg_ready, 0);
    cyc(8'h37);
    chk("a_cnt37", count, 8'h37);
    chk("a_busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("a_async_cnt", count, 0);
    chk("a_async_ready", cif.cfg_ready, 1);
    chk("a_async_busy", busy, 0);
    chk("a_async_tick", tick, 0);
    cyc(1);
    rst = 1'b0;

    // ONESHOT limit=5 presc=2
    cfg_set(2'd1, 8'd5, 16'd2);
    start = 1'b1;
    cyc(1);
    cif.cfg_valid = 1'b0;
    start = 1'b0;
    chk("b_cnt0", count, 0);
    cyc(2);
    chk("b_hold_presc", count, 0);
    cyc(1);
    chk("b_cnt1", count, 1);
    cyc(3);
    chk("b_cnt2", count, 2);
    cyc(3);
    chk("b_cnt3", count, 3);
    cyc(3);
    chk("b_cnt4", count, 4);
    cyc(3);
    chk("b_cnt5", count, 5);
    cyc(2);
    chk("b_pre_done", done, 0);
    chk("b_pre_tick", tick, 0);
    cyc(1);
    chk("b_done", done, 1);
    chk("b_tick", tick, 1);
    chk("b_cnt_held", count, 5);
    chk("b_ready", cif.cfg_ready, 1);
    chk("b_busy", busy, 0);
    cyc(1);
    chk("b_tick_one", tick, 0);
    chk("b_done_lvl", done, 1);

    // ONESHOT limit=0 from DONE
    cfg_set(2'd1, 8'd0, 16'd0);
    start = 1'b1;
    cyc(1);
    cif.cfg_valid = 1'b0;
    start = 1'b0;
    chk("z_restart_cnt", count, 0);
    chk("z_restart_done", done, 0);
    cyc(1);
    chk("z_done", done, 1);
    chk("z_tick", tick, 1);
    chk("z_cnt", count, 0);

    // FREE, limit=3 ignored, 256 steps
    cfg_set(2'd0, 8'd3, 16'd0);
    start = 1'b1;
    cyc(1);
    cif.cfg_valid = 1'b0;
    start = 1'b0;
    ticks = 0;
    c4 = 8'd0;
    for (int i = 1; i <= 256; i++) begin
      cyc(1);
      if (tick) ticks++;
      if (i == 4) c4 = count;
      if (i == 255) chk("c_cnt255", count, 8'hff);
    end
    chk("c_past_limit", c4, 4);
    chk("c_wrap_cnt", count, 0);
    chk("c_wrap_tick", tick, 1);
    chk("c_tick_total", ticks, 1);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    chk("c_stop_busy", busy, 0);
    chk("c_stop_tick", tick, 0);

    // RELOAD limit=3 presc=0
    cfg_set(2'd2, 8'd3, 16'd0);
    start = 1'b1;
    cyc(1);
    cif.cfg_valid = 1'b0;
    start = 1'b0;
    ticks = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      chk($sformatf("d_cnt%0d", i), count, rl_cnt[i]);
      if (tick) ticks++;
    end
    chk("d_ticks", ticks, 2);
    cyc(2);
    chk("d_pre_pause", count, 2);
    pause = 1'b1;
    cyc(1);
    chk("d_pause_cnt", count, 2);
    chk("d_pause_busy", busy, 0);
    cyc(9);
    pause = 1'b0;
    chk("d_pause_hold", count, 2);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("d_resume_cnt", count, 2);
    chk("d_resume_busy", busy, 1);
    cyc(1);
    chk("d_resume_step", count, 3);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;

    // BOUNCE limit=2 presc=0
    cfg_set(2'd3, 8'd2, 16'd0);
    start = 1'b1;
    cyc(1);
    cif.cfg_valid = 1'b0;
    start = 1'b0;
    chk("e_cnt_init", count, 0);
    for (int i = 0; i < 7; i++) begin
      cyc(1);
      chk($sformatf("e_cnt%0d", i), count, bn_cnt[i]);
      chk($sformatf("e_dir%0d", i), dir, bn_dir[i]);
      chk($sformatf("e_tick%0d", i), tick, bn_tck[i]);
    end

    // Config offered while running must stall
    cfg_set(2'd0, 8'd7, 16'd5);
    #1;
    chk("f_ready_run", cif.cfg_ready, 0);
    cyc(2);
    chk("f_cfg_kept_cnt", count, 2);
    chk("f_cfg_kept_dir", dir, 1);
    chk("f_cfg_kept_tick", tick, 1);
    cif.cfg_valid = 1'b0;
    stop  = 1'b1;
    start = 1'b1;
    cyc(1);
    stop  = 1'b0;
    start = 1'b0;
    chk("f_prio_busy", busy, 0);
    chk("f_prio_done", done, 0);
    chk("f_prio_ready", cif.cfg_ready, 1);
    chk("f_prio_cnt", count, 2);
    chk("f_prio_tick", tick, 0);
`ifdef CNT_SEQUENCER_IRQ_EN
    chk("g_irq_set", irq, 1);
    irq_clr = 1'b1;
    cyc(1);
    irq_clr = 1'b0;
    chk("g_irq_clr", irq, 0);
`endif

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/cnt_sequencer.md
Name: cnt_sequencer

Overview:
Controller that sequences the tile's 8-bit display counter.
- Accepts a configuration over a valid/ready handshake, applies a programmable prescaler, and steps the count according to one of four modes.
- Drives `count` onto the output pins, plus status and event pulses.
- Sits between the tile's input pins (command source) and the `uo_out` counter display.

Parameters:
- WIDTH, 8: counter width in bits.
- PRESC_W, 16: prescaler width in bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_valid  in  1  configuration offered.
- cfg_ready  out  1  configuration can be accepted.
- cfg_mode  in  2  0 FREE, 1 ONESHOT, 2 RELOAD, 3 BOUNCE.
- cfg_limit  in  WIDTH  terminal count.
- cfg_presc  in  PRESC_W  prescaler divide minus 1.
- start  in  1  start or resume.
- pause  in  1  suspend counting.
- stop  in  1  abort to IDLE.
- count  out  WIDTH  current count.
- dir  out  1  1 = counting down (BOUNCE only).
- busy  out  1  state is RUN.
- done  out  1  state is DONE.
- tick  out  1  one-cycle event pulse.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; count=0; dir=0; tick=0; presc_cnt=0.
  - Shadow config: mode=0, limit=all-ones, presc=0.
  - cfg_ready=1; busy=0; done=0.
- States: IDLE, RUN, PAUSE, DONE. State encoding is internal only.
- Config handshake:
  - cfg_ready=1 only in IDLE or DONE.
  - Transfer occurs on a cycle where cfg_valid && cfg_ready; mode, limit and presc are latched into shadow registers.
  - count and presc_cnt are not altered by a config transfer.
  - cfg_valid during RUN or PAUSE stalls with no side effect.
- IDLE/DONE + start -> RUN:
  - count<=0, presc_cnt<=0, dir<=0 on the same edge.
  - A config transfer and start in the same cycle: the new config takes effect for this run.
- RUN + pause -> PAUSE: count and presc_cnt are held.
- PAUSE + start -> RUN: resumes without clearing.
- stop from any state -> IDLE on the next edge; count held; tick forced 0.
- Priority: stop > start > pause.
  - pause and start together in RUN: stays RUN.
- Prescaler (RUN only):
  - A step fires when presc_cnt==presc; presc_cnt then <=0, otherwise presc_cnt+1.
  - presc=0 gives a step every cycle. Step period is presc+1 cycles.
- Actions on a step, by mode:
  - FREE: count+1 modulo 2^WIDTH. tick=1 on the 255->0 wrap; limit is ignored.
  - ONESHOT: if count==limit, -> DONE with tick=1 and count held; else count+1.
    - limit=0: first step goes to DONE with count=0.
  - RELOAD: if count==limit, count<=0 and tick=1; else count+1.
  - BOUNCE: counts up to limit, then down to 0, and repeats.
    - At each endpoint: dir toggles, tick=1, count does not move on that step.
    - limit=0: dir toggles and tick=1 on every step.
- tick is registered: high for exactly one cycle, on the cycle following the triggering step edge.
- busy = (state==RUN). done = (state==DONE), level, cleared by start, stop or reset.
- Reset asserted mid-run: immediate return to the reset values above; no tick is emitted.

Optional Feature:
Macro: `CNT_SEQUENCER_IRQ_EN`
- Defined:
  - Adds ports `irq` (out, 1) and `irq_clr` (in, 1).
  - irq is sticky: set by tick, cleared by irq_clr.
  - Simultaneous tick and irq_clr: irq stays set.
  - irq reset value is 0.
- Undefined: neither port exists and there is no related logic.

Test Plan:
- Reset mid-count (count=0x37, RUN): assert rst -> count=0, state IDLE, cfg_ready=1, tick=0 immediately, without waiting for a clock edge.
- Config mode=1, limit=5, presc=2; pulse start:
  - count increments every 3 cycles: 0,1,...,5.
  - Next step -> done=1, tick pulse once, count stays 5, cfg_ready=1.
- FREE mode, presc=0: run 256 cycles -> count wraps 255->0 with exactly one tick; FREE ignores limit.
- RELOAD mode, limit=3, presc=0:
  - count sequence 0,1,2,3,0,1,...
  - tick once per 4 steps.
  - pause for 10 cycles holds count; start resumes from the held value.
- BOUNCE mode, limit=2, presc=0: count sequence 0,1,2,2,1,0,0,1...; dir toggles at each 2 and 0; tick at each endpoint.
- Handshake and priority:
  - cfg_valid held during RUN -> cfg_ready=0 and config unchanged.
  - stop and start asserted together -> IDLE.
  - With `CNT_SEQUENCER_IRQ_EN`: irq sets on tick and clears on irq_clr.
